uart_recv_bytes: RTL

//  Receive-side counterpart of the multi-byte UART sender. Collects BYTES_NUM consecutive

---
 rtl/uart_recv_bytes_pkg.sv | 23 ++
 rtl/uart_recv_bytes_if.sv | 20 ++
 rtl/uart_recv_bytes_edge_det.sv | 26 ++
 rtl/uart_recv_bytes.sv | 131 +++++++++++++
 4 files changed

// File: rtl/uart_recv_bytes_pkg.sv
// Shared definitions for the multi-byte UART receive path: default word
// geometry, FSM state type and the helper that masks unused word bytes.
package uart_recv_bytes_pkg;

  localparam int unsigned BYTES_NUM_DEF   = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 50000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } recv_state_t;

  // Ones over the low nbytes bytes of the 32-bit word, zeros above.
  function automatic logic [31:0] word_mask(input int unsigned nbytes);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < nbytes && i < 4; i++) begin
      m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/uart_recv_bytes_if.sv
// Byte-in / word-out bundle between the UART RX core and the word assembler.
// master: the side feeding bytes and consuming words; slave: the assembler.
interface uart_recv_bytes_if;
  logic        Uart_RX_done;
  logic [7:0]  Uart_dout;
  logic [31:0] Bytes_DR;
  logic        Bytes_valid;
  logic        Bytes_busy;
  logic        Bytes_err;

  modport master (
    output Uart_RX_done, Uart_dout,
    input  Bytes_DR, Bytes_valid, Bytes_busy, Bytes_err
  );

  modport slave (
    input  Uart_RX_done, Uart_dout,
    output Bytes_DR, Bytes_valid, Bytes_busy, Bytes_err
  );
endinterface

// File: rtl/uart_recv_bytes_edge_det.sv
// Two-flop delay line with a rising-edge pulse; a level held high for many
// cycles produces exactly one pulse.
module uart_edge_det (
  input  logic CLK_SYS,
  input  logic CLK_RST,
  input  logic sig_in,
  output logic sig_rise
);

  logic done_d0;
  logic done_d1;

  // Delay the input twice so the rise can be seen as 1-then-0 history.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      done_d0 <= 1'b0;
      done_d1 <= 1'b0;
    end else begin
      done_d0 <= sig_in;
      done_d1 <= done_d0;
    end
  end

  assign sig_rise = done_d0 & ~done_d1;

endmodule

// File: rtl/uart_recv_bytes.sv
// Assembles BYTES_NUM received bytes, first byte most significant, into one
// word with a one-cycle valid strobe; an inter-byte timeout drops partial
// frames with a one-cycle error strobe.
module uart_recv_bytes
  import uart_recv_bytes_pkg::*;
#(
  parameter int unsigned BYTES_NUM   = BYTES_NUM_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic             CLK_SYS,
  input logic             CLK_RST,
  uart_recv_bytes_if.slave bus
);

  localparam int unsigned       TW       = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]        CNT_LAST = 3'(BYTES_NUM);
  localparam logic [31:0]       DR_MASK  = word_mask(BYTES_NUM);

  recv_state_t   state_q, state_nxt;
  logic [2:0]    cnt_q, cnt_nxt;
  // Only the bytes preceding the final one need storing; the final byte is
  // taken straight from Uart_dout when the word is assembled.
  logic [23:0]   shift_q, shift_nxt;
  logic [TW-1:0] tmo_q, tmo_nxt;
  logic [31:0]   dr_q, dr_nxt;
  logic          valid_q, valid_nxt;
  logic          busy_q, busy_nxt;
  logic          err_q, err_nxt;

  logic          byte_flag;
  logic [31:0]   assembled;

  uart_edge_det u_done_edge (
    .CLK_SYS  (CLK_SYS),
    .CLK_RST  (CLK_RST),
    .sig_in   (bus.Uart_RX_done),
    .sig_rise (byte_flag)
  );

  assign assembled = {shift_q, bus.Uart_dout};

  // State, counters and output registers.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      tmo_q   <= '0;
      dr_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      shift_q <= shift_nxt;
      tmo_q   <= tmo_nxt;
      dr_q    <= dr_nxt;
      valid_q <= valid_nxt;
      busy_q  <= busy_nxt;
      err_q   <= err_nxt;
    end
  end

  // Next-state: accept bytes, finish frames, expire stalled frames (a byte
  // arriving on the expiry cycle takes priority over the timeout).
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    shift_nxt = shift_q;
    tmo_nxt   = tmo_q;
    dr_nxt    = dr_q;
    valid_nxt = 1'b0;
    busy_nxt  = busy_q;
    err_nxt   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (byte_flag) begin
          tmo_nxt = '0;
          if (BYTES_NUM == 1) begin
            dr_nxt    = assembled & DR_MASK;
            valid_nxt = 1'b1;
            cnt_nxt   = '0;
            shift_nxt = '0;
          end else begin
            // Fresh load so a previous frame never leaks into this word.
            shift_nxt = {16'h0, bus.Uart_dout};
            cnt_nxt   = 3'd1;
            busy_nxt  = 1'b1;
            state_nxt = S_RECV;
          end
        end
      end

      S_RECV: begin
        if (byte_flag) begin
          shift_nxt = assembled[23:0];
          tmo_nxt   = '0;
          if (cnt_q + 3'd1 == CNT_LAST) begin
            dr_nxt    = assembled & DR_MASK;
            valid_nxt = 1'b1;
            busy_nxt  = 1'b0;
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt_q + 3'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
          shift_nxt = '0;
          tmo_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (tmo_q != '1) begin
          tmo_nxt = tmo_q + 1'b1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.Bytes_DR    = dr_q;
  assign bus.Bytes_valid = valid_q;
  assign bus.Bytes_busy  = busy_q;
  assign bus.Bytes_err   = err_q;

endmodule
